mem_sequencer: RTL and testbench

Multicycle memory-access sequencer between the CPU datapath/control and the unified 64-word instruction/data memory. Serialises instruction fetches, word loads and word stores onto the memory's single address/strobe interface. Owns the program counter, instruction register (IR) and memory data register (MDR). Reports completion and faults to the control unit through a busy/done/err handshake.

---
 rtl/mem_sequencer_if.sv | 32 +++
 rtl/mem_sequencer.sv | 115 +++++++++++
 tb/tb_mem_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_sequencer_if.sv
// Request, status and memory-bus bundle between the control unit/memory and mem_sequencer.
// The sequencer takes the slave view. The master view belongs to the control unit and the memory.
interface mem_sequencer_if;
  logic        fetch_req;
  logic        ld_req;
  logic        st_req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        pc_load;
  logic [31:0] pc_in;
  logic [31:0] mem_rdata;
  logic [31:0] mem_dir;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wd;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  fetch_req, ld_req, st_req, addr, wdata, pc_load, pc_in, mem_rdata,
    output mem_dir, mem_wdata, mem_rd, mem_wd, pc, ir, mdr, busy, done, err
  );

  modport master (
    output fetch_req, ld_req, st_req, addr, wdata, pc_load, pc_in, mem_rdata,
    input  mem_dir, mem_wdata, mem_rd, mem_wd, pc, ir, mdr, busy, done, err
  );
endinterface

// File: rtl/mem_sequencer.sv
// Multicycle sequencer that places fetches, loads and stores on one memory port.
// It holds the PC, the IR and the MDR, and signals completion and faults with busy/done/err.
module mem_sequencer #(
  parameter logic [31:0] BASE  = 32'h0040_0000,
  parameter int          WORDS = 64
) (
  input  logic            clk,
  input  logic            reset,
  mem_sequencer_if.slave  bus
);
  localparam logic [31:0] SPAN = 32'(4 * WORDS);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  // The address must be word-aligned and lie inside the backing store.
  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && ((a - BASE) < SPAN);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= BASE;
      ir_q    <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.pc_load) begin
          pc_d = bus.pc_in;
        end else if (bus.st_req) begin
          if (legal(bus.addr)) begin
            addr_d  = bus.addr;
            data_d  = bus.wdata;
            state_d = S_STORE;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end else if (bus.ld_req) begin
          if (legal(bus.addr)) begin
            addr_d  = bus.addr;
            state_d = S_LOAD;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end else if (bus.fetch_req) begin
          if (legal(pc_q)) begin
            state_d = S_FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        ir_d    = bus.mem_rdata;
        pc_d    = pc_q + 32'd4;
        state_d = S_DONE;
      end
      S_LOAD: begin
        mdr_d   = bus.mem_rdata;
        state_d = S_DONE;
      end
      S_STORE: state_d = S_DONE;
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode from state only, so reset pulls them low at once.
  assign bus.mem_rd    = (state_q == S_FETCH) || (state_q == S_LOAD);
  assign bus.mem_wd    = (state_q == S_STORE);
  assign bus.mem_dir   = ((state_q == S_LOAD) || (state_q == S_STORE)) ? addr_q : pc_q;
  assign bus.mem_wdata = (state_q == S_STORE) ? data_q : 32'h0;
  assign bus.pc        = pc_q;
  assign bus.ir        = ir_q;
  assign bus.mdr       = mdr_q;
  assign bus.busy      = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_STORE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = (state_q == S_DONE) && err_q;
endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: directed plan steps followed by random accesses.
// The results are compared against an architectural model of PC, IR, MDR and memory.
module tb_mem_sequencer;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          WORDS = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_sequencer_if bus ();
  mem_sequencer #(.BASE(BASE), .WORDS(WORDS)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Backing memory: combinational read, write on the strobe, plus a preload port.
  logic [31:0] mem [0:WORDS-1];
  logic        pre_en  = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  wire  [31:0] mem_off = bus.mem_dir - BASE;
  assign bus.mem_rdata = (mem_off < 32'(4 * WORDS)) ? mem[mem_off[7:2]] : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (bus.mem_wd && (mem_off < 32'(4 * WORDS))) mem[mem_off[7:2]] <= bus.mem_wdata;
  end

  // Architectural reference state.
  logic [31:0] ref_mem [0:WORDS-1];
  logic [31:0] ref_pc, ref_ir, ref_mdr;
  int n_pass = 0, n_total = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a);
    longint unsigned v = longint'(a);
    return (v % 4 == 0) && (v >= longint'(BASE)) && (v < longint'(BASE) + 4 * WORDS);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic clear_reqs();
    bus.fetch_req = 1'b0; bus.ld_req = 1'b0; bus.st_req = 1'b0; bus.pc_load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"},    {31'b0, bus.mem_rd},   32'd0);
    check({tag, "_wd"},    {31'b0, bus.mem_wd},   32'd0);
    check({tag, "_busy"},  {31'b0, bus.busy},     32'd0);
    check({tag, "_done"},  {31'b0, bus.done},     32'd0);
    check({tag, "_err"},   {31'b0, bus.err},      32'd0);
    check({tag, "_pc"},    bus.pc,                BASE);
    check({tag, "_ir"},    bus.ir,                32'd0);
    check({tag, "_mdr"},   bus.mdr,               32'd0);
    check({tag, "_dir"},   bus.mem_dir,           BASE);
    check({tag, "_wdata"}, bus.mem_wdata,         32'd0);
  endtask

  // op: 0 fetch, 1 load, 2 store, 3 pc_load (a is the new PC).
  // extra raises every lower-priority request on the same edge; poke raises fetch_req while busy/done.
  // The task is entered at 1 ns after a rising edge, with the DUT in IDLE.
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] d,
                       input bit extra, input bit poke);
    logic [31:0] target;
    bit ok;
    string name;
    name = (op == 0) ? "FETCH" : (op == 1) ? "LOAD" : (op == 2) ? "STORE" : "PCLOAD";
    clear_reqs();
    bus.addr = a; bus.wdata = d; bus.pc_in = a;
    case (op)
      0: bus.fetch_req = 1'b1;
      1: begin bus.ld_req = 1'b1; bus.fetch_req = extra; end
      2: begin bus.st_req = 1'b1; bus.ld_req = extra; bus.fetch_req = extra; end
      default: begin bus.pc_load = 1'b1; bus.st_req = extra; bus.ld_req = extra; bus.fetch_req = extra; end
    endcase
    if (op == 3) begin
      ref_pc = a;
      @(posedge clk); #1;
      clear_reqs();
      check("pcload_pc", bus.pc, ref_pc);
      check("pcload_busy", {31'b0, bus.busy}, 32'd0);
      check("pcload_rd", {31'b0, bus.mem_rd | bus.mem_wd}, 32'd0);
      $display("op=%s pc=%h", name, bus.pc);
      return;
    end
    target = (op == 0) ? ref_pc : a;
    ok = is_legal(target);
    @(posedge clk); #1;
    clear_reqs();
    bus.fetch_req = poke;
    if (ok) begin
      check("acc_busy", {31'b0, bus.busy}, 32'd1);
      check("acc_rd", {31'b0, bus.mem_rd}, (op != 2) ? 32'd1 : 32'd0);
      check("acc_wd", {31'b0, bus.mem_wd}, (op == 2) ? 32'd1 : 32'd0);
      check("acc_dir", bus.mem_dir, target);
      if (op == 2) check("acc_wdata", bus.mem_wdata, d);
      case (op)
        0: begin ref_ir = ref_mem[word_of(target)]; ref_pc = ref_pc + 32'd4; end
        1: ref_mdr = ref_mem[word_of(target)];
        default: ref_mem[word_of(target)] = d;
      endcase
      @(posedge clk); #1;
    end
    check("done", {31'b0, bus.done}, 32'd1);
    check("err", {31'b0, bus.err}, ok ? 32'd0 : 32'd1);
    check("done_strobes", {30'b0, bus.mem_rd, bus.mem_wd}, 32'd0);
    check("done_busy", {31'b0, bus.busy}, 32'd0);
    check("pc", bus.pc, ref_pc);
    check("ir", bus.ir, ref_ir);
    check("mdr", bus.mdr, ref_mdr);
    if (op == 2 && ok) check("mem_word", mem[word_of(target)], ref_mem[word_of(target)]);
    @(posedge clk); #1;
    bus.fetch_req = 1'b0;
    check("idle_done", {30'b0, bus.done, bus.err}, 32'd0);
    check("idle_dir", bus.mem_dir, ref_pc);
    $display("op=%s target=%h legal=%0d pc=%h ir=%h mdr=%h", name, target, ok, bus.pc, bus.ir, bus.mdr);
  endtask

  initial begin
    logic [31:0] a, d;
    int op, kind;
    clear_reqs();
    bus.addr = '0; bus.wdata = '0; bus.pc_in = '0;
    ref_pc = BASE; ref_ir = '0; ref_mdr = '0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = $urandom;
    ref_mem[0]  = 32'h8DEA_0050;
    ref_mem[20] = 32'd18;
    ref_mem[4]  = 32'hCAFE_0010;
    for (int i = 0; i < WORDS; i++) begin
      pre_en = 1'b1; pre_idx = 6'(i); pre_val = ref_mem[i];
      @(posedge clk); #1;
    end
    pre_en = 1'b0;
    check_reset_outputs("rst_held");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst_rel");

    do_op(0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("plan_ir", bus.ir, 32'h8DEA_0050);
    check("plan_pc", bus.pc, 32'h0040_0004);
    do_op(1, 32'h0040_0050, 32'h0, 1'b0, 1'b0);
    check("plan_ld", bus.mdr, 32'd18);
    do_op(2, 32'h0040_0058, 32'd25, 1'b0, 1'b0);
    do_op(1, 32'h0040_0058, 32'h0, 1'b0, 1'b0);
    check("plan_ldst", bus.mdr, 32'd25);
    do_op(2, 32'h0040_0002, 32'd7, 1'b0, 1'b0);
    do_op(1, 32'h003F_FFFC, 32'h0, 1'b0, 1'b0);
    do_op(1, 32'h0040_0100, 32'h0, 1'b0, 1'b0);
    check("plan_mdr_kept", bus.mdr, 32'd25);
    do_op(2, 32'h0040_0060, 32'd77, 1'b1, 1'b1);
    check("plan_prio_pc", bus.pc, 32'h0040_0004);
    do_op(3, 32'h0040_0010, 32'h0, 1'b1, 1'b0);
    check("plan_mem_after_pcload", mem[24], 32'd77);
    do_op(0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("plan_fetch10", bus.ir, 32'hCAFE_0010);

    // Reset asserted in the middle of a store cycle.
    a = 32'h0040_0070; d = ref_mem[28];
    clear_reqs(); bus.st_req = 1'b1; bus.addr = a; bus.wdata = ~d;
    @(posedge clk); #1;
    clear_reqs();
    check("mid_store_wd", {31'b0, bus.mem_wd}, 32'd1);
    reset = 1'b1; #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    check("rst_no_write", mem[28], d);
    reset = 1'b0;
    ref_pc = BASE; ref_ir = '0; ref_mdr = '0;
    @(posedge clk); #1;

    for (int n = 0; n < 120; n++) begin
      op = int'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 9));
      case (kind)
        0: a = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(1, 3));
        1: a = BASE - 32'(4 * $urandom_range(1, 8));
        2: a = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 8));
        3: a = BASE + 32'(4 * (WORDS - 1));
        default: a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
      endcase
      d = $urandom;
      do_op(op, a, d, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
